mac_horner_engine: RTL
======================

Name: mac_horner_engine

Overview:
Parametrised polynomial evaluator built on a single multiply-accumulate datapath. It computes p(x) = c[N]*x^N + ... + c[1]*x + c[0] by Horner's rule, acc <= acc*x + c, with coefficients streamed highest order first. It generalises the fixed 8-bit trinomial MAC mode to arbitrary data width, accumulator width and polynomial degree. It adds valid/ready handshakes on coefficient input and result output, plus overflow reporting. It sits between a coefficient source (FIFO or controller) and a result consumer in the MAC project datapath.

Parameters:
DATA_W, 8, width of x and of each coefficient (unsigned)
ACC_W, 16, accumulator/result width (must be >= DATA_W)
MAX_DEG, 4, maximum supported polynomial degree
DEG_W, $clog2(MAX_DEG+1), width of degree field (derived; not to be overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin an evaluation; sampled only in IDLE
x_in  input  DATA_W  evaluation point, latched on accepted start
degree  input  DEG_W  polynomial degree N, latched on accepted start
coef_valid  input  1  coefficient available on coef_in
coef_ready  output  1  engine accepts a coefficient this cycle
coef_in  input  DATA_W  coefficient, highest order first
result  output  ACC_W  evaluated polynomial
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
busy  output  1  high in any state other than IDLE
ovf  output  1  overflow occurred during the current or last evaluation

Behaviour:
- Reset (sync, active-high, highest priority):
  - FSM goes to IDLE.
  - acc, result, count, x register, ovf all cleared to 0.
  - coef_ready=0, result_valid=0, busy=0.
  - Reset mid-evaluation abandons it. Coefficients presented during reset are not consumed.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On start=1: latch x_in, and latch count <= min(degree, MAX_DEG).
  - Clear acc and ovf, then go to ACCUM.
  - Degree values above MAX_DEG are clamped.
- ACCUM:
  - coef_ready=1 for the whole state.
  - A transfer occurs when coef_valid & coef_ready are both high.
  - On each transfer: acc <= acc*x + coef_in, computed at full width ACC_W+DATA_W+1, then reduced to ACC_W.
  - The first transfer yields acc = coef_in, because acc starts at 0.
  - On a transfer with count==0, go to DONE. Otherwise count decrements.
  - Exactly N+1 transfers are consumed. coef_valid low stalls the engine with no state change. Maximum throughput is one coefficient per cycle.
- DONE:
  - result_valid=1; result holds the final acc and stays stable until result_ready=1.
  - On result_valid & result_ready, go to IDLE.
  - result keeps its value in IDLE until the next accepted start.
- Latency:
  - coef_ready rises the cycle after start is accepted.
  - result_valid rises the cycle after the last coefficient transfer.
  - Minimum total is N+3 cycles from start to IDLE, with result_ready tied high.
- Overflow:
  - ovf is set (sticky) if any step's full-width value exceeds 2^ACC_W-1.
  - It is cleared only by reset or an accepted start, and remains readable in DONE and in IDLE.
  - Default reduction is modulo 2^ACC_W (wrap).
- Simultaneous or illegal events:
  - start while busy=1 is ignored.
  - start and result handshake in the same DONE cycle: the handshake completes, and start is not accepted until the engine is in IDLE.
  - coef_valid outside ACCUM is ignored (coef_ready=0).
- All arithmetic is unsigned.

Optional Feature:
MAC_HORNER_SAT_EN:
- Defined: each step clamps to 2^ACC_W-1 when overflow occurs, and ovf is still set. Later steps use the clamped acc.
- Undefined: each step wraps modulo 2^ACC_W, and ovf is still set.
- No port changes either way.

Test Plan:
1. Trinomial, defaults, x=3, degree=2, coefs 5,2,1 on consecutive cycles -> result=52, ovf=0, result_valid exactly 1 cycle after third transfer.
2. Degree 0, x=9, coef 7 -> result=7 after a single transfer. Then degree=7 with MAX_DEG=4 -> exactly 5 coefficients consumed.
3. Backpressure: x=2, degree=3, coefs 1,0,0,1 with coef_valid gaps of 2 cycles, then result_ready low for 3 cycles -> result=9, held stable with result_valid high until the handshake.
4. Overflow: DATA_W=8, ACC_W=16, x=255, degree=2, coefs 255,255,255 -> ovf=1. result=511 with the macro undefined; result=65535 with MAC_HORNER_SAT_EN defined.
5. Reset mid-op: assert reset after 2 of 4 coefficients -> next cycle busy=0, coef_ready=0, result=0, ovf=0. A new evaluation afterwards gives the correct value.
6. start pulsed during ACCUM and DONE -> ignored, with no change to x or count. A start in IDLE after completion clears ovf.

Source files
------------

// File: rtl/mac_horner_engine.sv
// Horner-rule polynomial evaluator on one multiply-accumulate datapath, valid/ready on both sides.
// Optional MAC_HORNER_SAT_EN: clamp each overflowing step to all-ones instead of wrapping.
module mac_horner_engine #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int MAX_DEG = 4,
    parameter int DEG_W   = $clog2(MAX_DEG + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DEG_W-1:0]  degree,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [DATA_W-1:0] coef_in,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              ovf
);
    localparam int FULL_W = ACC_W + DATA_W + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc, acc_next;
    logic [DATA_W-1:0]  x_reg;
    logic [DEG_W-1:0]   count, deg_clamped;
    logic [FULL_W-1:0]  full;
    logic               step_ovf, xfer;

    assign xfer        = coef_valid && coef_ready;
    assign deg_clamped = (degree > DEG_W'(MAX_DEG)) ? DEG_W'(MAX_DEG) : degree;

    // Full-width step cannot overflow FULL_W, so step_ovf is exact.
    always_comb begin
        full     = FULL_W'(acc) * FULL_W'(x_reg) + FULL_W'(coef_in);
        step_ovf = |full[FULL_W-1:ACC_W];
`ifdef MAC_HORNER_SAT_EN
        acc_next = step_ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
        acc_next = full[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (xfer && count == '0) state_next = DONE;
            DONE:    if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        coef_ready   = (state == ACCUM);
        result_valid = (state == DONE);
        busy         = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            x_reg <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            acc   <= '0;
            x_reg <= x_in;
            count <= deg_clamped;
            ovf   <= 1'b0;
        end else if (xfer) begin
            acc <= acc_next;
            ovf <= ovf | step_ovf;
            if (count != '0) count <= count - 1'b1;
        end
    end

    // Accumulator doubles as the result register; it only changes on start or a transfer.
    assign result = acc;
endmodule
